// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns pc_F, talks to the icache and fills the F/D
// pipeline register. A small FSM rides out icache misses and, when a redirect
// arrives during a line fill, parks the target until the fill has drained.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   RUN       | normal fetch, one instruction per hit
//   WAIT_MISS | icache miss outstanding, waiting for the hit at pc_F
//   DROP      | redirected during a fill; discard returns, then jump to target
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_1000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_F_in,
  input  logic            flush_D_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] pc_target_in,
  input  logic            icache_hit_in,
  input  logic [XLEN-1:0] icache_instr_in,
  input  logic            icache_mem_req_in,
  output logic            icache_req_out,
  output logic [XLEN-1:0] icache_addr_out,
  output logic [XLEN-1:0] instr_D_out,
  output logic [XLEN-1:0] pc_D_out,
  output logic [XLEN-1:0] pc_plus4_D_out,
  output logic            valid_D_out
);

  // pc_src encoding: only FROM_A redirects, every other code is sequential.
  localparam logic [1:0] FROM_A = 2'b01;

  typedef enum logic [1:0] {RUN, WAIT_MISS, DROP} state_e;

  state_e          state;
  state_e          state_nxt;
  logic [XLEN-1:0] pc_F;
  logic [XLEN-1:0] pc_F_nxt;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] redirect_pc_nxt;
  logic [XLEN-1:0] pc_plus4_F;
  logic [XLEN-1:0] target_aligned;
  logic            redirect;
  logic            fd_capture;
  logic            fd_hold;

  assign redirect       = (pc_src_in == FROM_A);
  assign target_aligned = {pc_target_in[XLEN-1:2], 2'b00};
  // Plain XLEN-bit add, so the top word wraps to zero.
  assign pc_plus4_F     = pc_F + XLEN'(4);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (!redirect && !stall_F_in && !icache_hit_in) state_nxt = WAIT_MISS;
      WAIT_MISS: begin
        if (redirect)           state_nxt = DROP;
        else if (icache_hit_in) state_nxt = RUN;
      end
      DROP:      if (!icache_mem_req_in) state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // Output and datapath control decode.
  always_comb begin
    icache_req_out  = !reset;
    icache_addr_out = pc_F;
    pc_F_nxt        = pc_F;
    redirect_pc_nxt = redirect_pc;
    fd_capture      = 1'b0;
    fd_hold         = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          pc_F_nxt = target_aligned;
        end else if (stall_F_in) begin
          // A hit under stall is not consumed; the same pc_F is fetched again.
          fd_hold = 1'b1;
        end else if (icache_hit_in) begin
          fd_capture = 1'b1;
          pc_F_nxt   = pc_plus4_F;
        end
      end
      WAIT_MISS: begin
        // pc_F stays put on redirect so the outstanding fill can complete.
        if (redirect) begin
          redirect_pc_nxt = target_aligned;
        end else if (icache_hit_in && !stall_F_in) begin
          fd_capture = 1'b1;
          pc_F_nxt   = pc_plus4_F;
        end
      end
      DROP: begin
        if (redirect) redirect_pc_nxt = target_aligned;
        if (!icache_mem_req_in) pc_F_nxt = redirect_pc_nxt;
      end
      default: ;
    endcase
  end

  // PC and parked redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F        <= RESET_PC;
      redirect_pc <= RESET_PC;
    end else begin
      pc_F        <= pc_F_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // F/D register: flush beats everything but reset; bubbles keep pc fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_D_out    <= NOP_INSTR;
      pc_D_out       <= '0;
      pc_plus4_D_out <= '0;
      valid_D_out    <= 1'b0;
    end else if (flush_D_in) begin
      instr_D_out <= NOP_INSTR;
      valid_D_out <= 1'b0;
    end else if (fd_capture) begin
      instr_D_out    <= icache_instr_in;
      pc_D_out       <= pc_F;
      pc_plus4_D_out <= pc_plus4_F;
      valid_D_out    <= 1'b1;
    end else if (!fd_hold) begin
      instr_D_out <= NOP_INSTR;
      valid_D_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming hits, redirect under stall,
// stall/flush interplay, miss handling, redirect during a fill and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;
  localparam logic [1:0]  SEQ  = 2'b00;
  localparam logic [1:0]  RDIR = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F_in;
  logic        flush_D_in;
  logic [1:0]  pc_src_in;
  logic [31:0] pc_target_in;
  logic        icache_hit_in;
  logic [31:0] icache_instr_in;
  logic        icache_mem_req_in;
  logic        icache_req_out;
  logic [31:0] icache_addr_out;
  logic [31:0] instr_D_out;
  logic [31:0] pc_D_out;
  logic [31:0] pc_plus4_D_out;
  logic        valid_D_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Cache model: the word returned at any address is that address salted.
  assign icache_instr_in = icache_addr_out ^ SALT;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall_F_in        (stall_F_in),
    .flush_D_in        (flush_D_in),
    .pc_src_in         (pc_src_in),
    .pc_target_in      (pc_target_in),
    .icache_hit_in     (icache_hit_in),
    .icache_instr_in   (icache_instr_in),
    .icache_mem_req_in (icache_mem_req_in),
    .icache_req_out    (icache_req_out),
    .icache_addr_out   (icache_addr_out),
    .instr_D_out       (instr_D_out),
    .pc_D_out          (pc_D_out),
    .pc_plus4_D_out    (pc_plus4_D_out),
    .valid_D_out       (valid_D_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdir, input logic [31:0] tgt, input logic stall,
                       input logic flush, input logic hit, input logic mreq);
    pc_src_in         = rdir ? RDIR : SEQ;
    pc_target_in      = tgt;
    stall_F_in        = stall;
    flush_D_in        = flush;
    icache_hit_in     = hit;
    icache_mem_req_in = mreq;
  endtask

  task automatic check_valid(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, valid_D_out}, 32'd1);
    check({tag, ".pc"},    pc_D_out, pc);
    check({tag, ".pc4"},   pc_plus4_D_out, pc + 32'd4);
    check({tag, ".instr"}, instr_D_out, pc ^ SALT);
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, valid_D_out}, 32'd0);
    check({tag, ".instr"}, instr_D_out, NOP);
    check({tag, ".addr"},  icache_addr_out, addr);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 32'h0, 0, 0, 1, 0);
    tick();
    tick();
    check("rst.req",   {31'd0, icache_req_out}, 32'd0);
    check("rst.addr",  icache_addr_out, 32'h1000);
    check("rst.pc_d",  pc_D_out, 32'h0);
    check("rst.pc4_d", pc_plus4_D_out, 32'h0);
    check_bubble("rst", 32'h1000);

    // Streaming hits out of reset.
    reset = 1'b0;
    #1;
    check("run.req", {31'd0, icache_req_out}, 32'd1);
    tick(); check_valid("seq0", 32'h1000);
    tick(); check_valid("seq1", 32'h1004);
    tick(); check_valid("seq2", 32'h1008);
    check("seq.addr", icache_addr_out, 32'h100C);

    // Redirect wins over stall; target is word-aligned.
    drive(1, 32'h2002, 1, 0, 1, 0);
    tick(); check_bubble("rdst", 32'h2000);
    check("rdst.pc_d", pc_D_out, 32'h1008);
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("rdst.tgt", 32'h2000);

    // Hit under stall is held and re-fetched, not lost.
    drive(0, 32'h0, 1, 0, 1, 0);
    tick(); check_valid("stall.hold", 32'h2000);
    check("stall.addr", icache_addr_out, 32'h2004);
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("stall.next", 32'h2004);

    // Flush beats stall, leaves pc_F alone.
    drive(0, 32'h0, 1, 1, 1, 0);
    tick(); check_bubble("sflush", 32'h2008);
    check("sflush.pc_d", pc_D_out, 32'h2004);
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("sflush.after", 32'h2008);

    // Miss at 0x1008 with a five-cycle fill.
    drive(1, 32'h1008, 0, 0, 1, 0);
    tick(); check_bubble("miss.rd", 32'h1008);
    drive(0, 32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); check_bubble($sformatf("miss.w%0d", i), 32'h1008);
    end
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("miss.hit", 32'h1008);
    tick(); check_valid("miss.next", 32'h100C);

    // Redirect during fill: returned 0x1008 is discarded.
    drive(1, 32'h1008, 0, 0, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0, 0, 1);
    tick(); check_bubble("drop.miss", 32'h1008);
    drive(1, 32'h3000, 0, 0, 0, 1);
    tick(); check_bubble("drop.enter", 32'h1008);
    drive(0, 32'h0, 0, 0, 1, 1);
    tick(); check_bubble("drop.discard", 32'h1008);
    drive(0, 32'h0, 0, 0, 0, 0);
    tick(); check_bubble("drop.exit", 32'h3000);
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("drop.tgt", 32'h3000);

    // Newer redirect in DROP replaces the parked target.
    drive(0, 32'h0, 0, 0, 0, 1);
    tick();
    drive(1, 32'h3100, 0, 0, 0, 1);
    tick();
    drive(1, 32'h5006, 0, 0, 0, 1);
    tick(); check_bubble("drop2.ovr", 32'h3004);
    drive(0, 32'h0, 0, 0, 0, 0);
    tick(); check_bubble("drop2.exit", 32'h5004);
    drive(0, 32'h0, 0, 0, 1, 0);
    tick(); check_valid("drop2.tgt", 32'h5004);

    // PC+4 wraps at the top of the address space.
    drive(1, 32'hFFFF_FFFC, 0, 0, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0, 1, 0);
    tick();
    check("wrap.pc_d",  pc_D_out, 32'hFFFF_FFFC);
    check("wrap.pc4_d", pc_plus4_D_out, 32'h0);
    check("wrap.addr",  icache_addr_out, 32'h0);

    // Reset while in DROP returns to RESET_PC in RUN.
    drive(0, 32'h0, 0, 0, 0, 1);
    tick();
    drive(1, 32'h7000, 0, 0, 0, 1);
    tick();
    drive(0, 32'h0, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    check("rdrop.req", {31'd0, icache_req_out}, 32'd0);
    check_bubble("rdrop", 32'h1000);
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 1, 1);
    tick(); check_valid("rdrop.run", 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_1000: PC after reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall_F_in  in  1  hold PC and F/D register.
REQ-007 flush_D_in  in  1  bubble the F/D register.
REQ-008 pc_src_in  in  pc_src_e  FROM_A = taken branch/jump redirect; any other value = sequential.
REQ-009 pc_target_in  in  XLEN  redirect target from the A stage.
REQ-010 icache_hit_in  in  1  icache_instr_in valid for icache_addr_out this cycle.
REQ-011 icache_instr_in  in  XLEN  fetched instruction.
REQ-012 icache_mem_req_in  in  1  icache line fill in progress.
REQ-013 icache_req_out  out  1  fetch request.
REQ-014 icache_addr_out  out  XLEN  fetch address (= pc_F).
REQ-015 instr_D_out  out  XLEN  F/D register instruction.
REQ-016 pc_D_out  out  XLEN  F/D register PC.
REQ-017 pc_plus4_D_out  out  XLEN  F/D register PC+4.
REQ-018 valid_D_out  out  1  F/D register holds a real instruction.

Function
REQ-019 SHALL hold pc_F and a three-state FSM: RUN, WAIT_MISS, DROP.
REQ-020 SHALL drive icache_req_out=1 in every state except during reset; icache_addr_out=pc_F always.
REQ-021 SHALL compute PC+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-022 SHALL force bits [1:0] of any loaded redirect target to 0.
REQ-023 RUN, redirect (pc_src_in==FROM_A): pc_F<=pc_target_in, F/D<=bubble, stay RUN; redirect wins over stall_F_in and over hit/miss.
REQ-024 RUN, no redirect, stall_F_in=1: pc_F and F/D unchanged unless flush_D_in.
REQ-025 RUN, no redirect, no stall, hit: F/D<={icache_instr_in, pc_F, pc_F+4, valid=1}; pc_F<=pc_F+4.
REQ-026 RUN, no redirect, no stall, miss (!icache_hit_in): F/D<=bubble, pc_F held, next state WAIT_MISS.
REQ-027 WAIT_MISS, no redirect: F/D<=bubble each cycle; on icache_hit_in capture as REQ-025 (unless stall_F_in) and return to RUN.
REQ-028 WAIT_MISS, redirect: latch target into redirect_pc, F/D<=bubble, go DROP; pc_F held so the outstanding fill completes.
REQ-029 DROP: F/D<=bubble; any instruction returned is discarded; newer redirect overwrites redirect_pc.
REQ-030 DROP exit: first cycle icache_mem_req_in=0 -> pc_F<=redirect_pc, state RUN; fetch of target starts next cycle.
REQ-031 Bubble = {NOP_INSTR, pc/pc+4 unchanged, valid=0}.
REQ-032 flush_D_in=1 SHALL bubble F/D in any state and wins over stall_F_in; it does not alter pc_F or FSM state.
REQ-033 Stall and flush SHALL never drop a fetched, non-redirected instruction: if hit coincides with stall_F_in, the fetch is repeated next cycle at the same pc_F.

Reset
REQ-034 reset SHALL, at the clock edge, set pc_F=RESET_PC, state=RUN, redirect_pc=RESET_PC, F/D to bubble with pc_D_out=0, pc_plus4_D_out=0, valid_D_out=0.
REQ-035 reset SHALL override all other inputs, including mid-miss and DROP; icache_req_out=0 while reset is high.

Verification
REQ-036 Release reset, always-hit cache, instr=i -> pc_D_out 0x1000,0x1004,0x1008 on consecutive cycles, valid_D_out=1 from 2nd cycle.
REQ-037 Redirect pc_target_in=0x2002 with stall_F_in=1 same cycle -> pc_F=0x2000 next cycle, valid_D_out=0, then pc_D_out=0x2000.
REQ-038 Miss at 0x1008, icache_mem_req_in high 5 cycles, then hit -> 5+ bubbles, then pc_D_out=0x1008 valid, no duplicate/skip.
REQ-039 Miss at 0x1008, redirect to 0x3000 during fill -> returned 0x1008 discarded, next valid pc_D_out=0x3000.
REQ-040 stall_F_in=1 and flush_D_in=1 together -> valid_D_out=0, instr_D_out=0x00000013, pc_F unchanged; reset asserted in DROP -> pc_F=0x1000, state RUN.
